// File: rtl/pipe_result_drain.sv
// Result drain FIFO for the free-running adder pipeline: buffers {cout, sum} and flags drops.
// Optional macro PIPE_DRAIN_CNT_EN adds an 8-bit saturating drop counter output.
module pipe_result_drain #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic [PTR_W:0]    level,
  output logic              full,
  output logic              ovf
`ifdef PIPE_DRAIN_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int unsigned EntryW = DATA_W + 1;
  localparam logic [PTR_W:0] LevelFull = (PTR_W + 1)'(DEPTH);

  if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : gen_bad_cfg
    $error("pipe_result_drain: DEPTH must be a power of two >= 2 and PTR_W == log2(DEPTH)");
  end

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, drop;
  logic [EntryW-1:0] head;

  assign full = (level_q == LevelFull);
  assign out_valid = (level_q != '0);
  assign pop = out_valid && out_ready;
  // A full FIFO still accepts a result when the head leaves on the same edge.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q || drop;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_cout, in_sum};
  end

  assign head     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_sum  = head[DATA_W-1:0];
  assign out_cout = head[DATA_W];
  assign level    = level_q;
  assign ovf      = ovf_q;

`ifdef PIPE_DRAIN_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_result_drain.sv
// Directed bench for pipe_result_drain: reset, ordering, full/drop, full with pop, mid-stream reset.
module tb_pipe_result_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_sum;
  logic       in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_cout;
  logic [2:0] level;
  logic       full;
  logic       ovf;
`ifdef PIPE_DRAIN_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_result_drain #(.DATA_W(8), .DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .level     (level),
    .full      (full),
    .ovf       (ovf)
`ifdef PIPE_DRAIN_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] s, input logic c);
    in_valid = 1'b1;
    in_sum   = s;
    in_cout  = c;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic head(input string tag, input logic [7:0] s, input logic c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(out_sum), 32'(s));
    chk({tag, "_cout"}, 32'(out_cout), 32'(c));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sum = 8'hAA; in_cout = 1'b0; out_ready = 1'b0;
    #1;
    cycle();
    cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    chk("idle_level", 32'(level), 32'd0);

    // Single pass-through
    out_ready = 1'b1;
    push(8'hAA, 1'b0);
    head("pass", 8'hAA, 1'b0);
    chk("pass_level1", 32'(level), 32'd1);
    cycle();
    chk("pass_level0", 32'(level), 32'd0);
    chk("pass_empty", 32'(out_valid), 32'd0);
    cycle();
    chk("empty_ready_level", 32'(level), 32'd0);

    // Ordering
    out_ready = 1'b0;
    push(8'h55, 1'b0);
    push(8'hFF, 1'b1);
    push(8'h0F, 1'b0);
    chk("ord_level", 32'(level), 32'd3);
    out_ready = 1'b1;
    head("ord0", 8'h55, 1'b0);
    cycle();
    head("ord1", 8'hFF, 1'b1);
    cycle();
    head("ord2", 8'h0F, 1'b0);
    cycle();
    chk("ord_empty", 32'(out_valid), 32'd0);

    // Full and drop
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_level", 32'(level), 32'd4);
    chk("full_ovf0", 32'(ovf), 32'd0);
    push(8'h05, 1'b0);
    chk("drop_ovf", 32'(ovf), 32'd1);
    chk("drop_level", 32'(level), 32'd4);
`ifdef PIPE_DRAIN_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    out_ready = 1'b1;
    head("drain1", 8'h01, 1'b0);
    cycle();
    head("drain2", 8'h02, 1'b0);
    cycle();
    head("drain3", 8'h03, 1'b0);
    cycle();
    head("drain4", 8'h04, 1'b0);
    cycle();
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Full with simultaneous push and pop
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst2_ovf", 32'(ovf), 32'd0);
    out_ready = 1'b0;
    push(8'h11, 1'b0);
    push(8'h22, 1'b1);
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);
    chk("fp_full", 32'(full), 32'd1);
    out_ready = 1'b1;
    push(8'h66, 1'b0);
    out_ready = 1'b0;
    chk("fp_level", 32'(level), 32'd4);
    chk("fp_ovf", 32'(ovf), 32'd0);
    out_ready = 1'b1;
    head("fp1", 8'h22, 1'b1);
    cycle();
    head("fp2", 8'h33, 1'b0);
    cycle();
    head("fp3", 8'h44, 1'b1);
    cycle();
    head("fp4", 8'h66, 1'b0);
    cycle();
    chk("fp_empty", 32'(out_valid), 32'd0);

    // Reset mid-stream, with ovf set beforehand
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'h80 + 8'(i), 1'b0);
    chk("mid_ovf1", 32'(ovf), 32'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("mid_level3", 32'(level), 32'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_level0", 32'(level), 32'd0);
    chk("mid_valid0", 32'(out_valid), 32'd0);
    chk("mid_ovf0", 32'(ovf), 32'd0);
`ifdef PIPE_DRAIN_CNT_EN
    chk("mid_cnt0", 32'(drop_cnt), 32'd0);
`endif
    push(8'h77, 1'b1);
    head("mid77", 8'h77, 1'b1);
    chk("mid_level1", 32'(level), 32'd1);
    out_ready = 1'b1;
    cycle();
    chk("mid_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_result_drain.md
Name: pipe_result_drain

Overview:
- Consumer end of the 8-bit pipelined adder datapath.
- Captures the sum and carry-out words that the free-running pipeline registers launch every cycle, and buffers them in a small FIFO.
- Presents the buffered results to a downstream reader over a valid/ready handshake.
- The adder pipeline cannot stall, so this block absorbs backpressure and flags any result it drops.

Parameters:
- DATA_W, 8, width of the sum word from the adder pipeline.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  the adder pipeline's final stage holds a new result this cycle.
- in_sum  input  DATA_W  sum from the adder pipeline.
- in_cout  input  1  carry-out from the adder pipeline.
- out_valid  output  1  the FIFO head is valid.
- out_ready  input  1  downstream reader accepts the head this cycle.
- out_sum  output  DATA_W  sum at the FIFO head.
- out_cout  output  1  carry-out at the FIFO head.
- level  output  PTR_W+1  number of occupied entries, 0..DEPTH.
- full  output  1  level == DEPTH.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset values: rst is sampled on the clk edge and is synchronous, active-high. When it is seen, wr_ptr=0, rd_ptr=0, level=0, out_valid=0, out_sum=0, out_cout=0, ovf=0, full=0. Stored data is don't-care. Reset mid-stream discards every buffered entry.
- Storage: each entry is {in_cout, in_sum}, DATA_W+1 bits.
- Push: push = in_valid && (!full || pop). On push, the entry is written at wr_ptr and wr_ptr increments modulo DEPTH (natural wrap).
- Pop: pop = out_valid && out_ready. On pop, rd_ptr increments modulo DEPTH.
- Level update: push only gives +1; pop only gives -1; both or neither leave level unchanged.
- Output path: out_sum and out_cout are the first-word-fall-through view of entry[rd_ptr], driven combinationally from the storage. out_valid = (level != 0).
- Latency: a result with in_valid high on edge N is visible on out_* after edge N, with out_valid=1, when the FIFO was empty. Minimum latency is one cycle; no bypass path exists.
- Full with simultaneous pop: the push is accepted and level stays at DEPTH.
- Full with no pop: the incoming result is dropped. Pointers and level are unchanged, and ovf is set on that edge. ovf holds until rst.
- Empty with out_ready high: no pop occurs, pointers are unchanged, out_valid=0, and out_sum/out_cout are don't-care.
- Simultaneous push and pop at level 1: the head advances to the new entry and out_valid stays 1.
- in_sum and in_cout are ignored whenever in_valid=0.

Optional Feature:
- Macro: PIPE_DRAIN_CNT_EN.
- Defined: adds output port drop_cnt, 8 bits, which counts dropped results (the ovf events). It saturates at 8'hFF and resets to 0 on rst. ovf remains present.
- Undefined: the port and counter do not exist, and only ovf reports drops.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_sum=8'hAA -> out_valid=0, level=0, ovf=0, full=0.
- Single pass-through: push {cout=0,sum=8'hAA} with out_ready=1 -> one cycle later out_valid=1 and out_sum=8'hAA; it pops on that edge and level returns to 0.
- Ordering: push 8'h55, 8'hFF (cout=1), 8'h0F on consecutive cycles with out_ready=0, then raise out_ready -> outputs 8'h55/0, 8'hFF/1, 8'h0F/0 in order, and out_valid falls after the third.
- Full and drop: with out_ready=0, push 5 results 8'h01..8'h05 -> full=1 and level=4 after the 4th; 8'h05 is dropped and ovf=1. Draining yields 8'h01..8'h04 only. With PIPE_DRAIN_CNT_EN, drop_cnt=1.
- Full with simultaneous push and pop: at level=4, push 8'h66 with out_ready=1 -> accepted, ovf stays 0, level stays 4, and 8'h66 is the last entry drained.
- Reset mid-stream: level=3, assert rst for 1 cycle -> level=0, out_valid=0, ovf=0. The next push of 8'h77 appears alone at the output.
